// File: rtl/alu_pkg.sv
// Shared execute-datapath definitions: default adder geometry and result flags.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_GROUP = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block: every carry is a flat
// sum-of-products over generate/propagate terms and cin, with no ripple.
module cla_group
  import alu_pkg::*;
#(
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             gen,
  output logic             prop,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             acc;
  logic             pp;

  // For bit i, acc collects every g[j] whose carry survives p[j+1..i] and pp is
  // p[0..i]. Both are rebuilt from scratch per bit, so no carry depends on another.
  always_comb begin
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = cin;
    acc  = 1'b0;
    pp   = 1'b0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int unsigned j = i; j > 0; j--) begin
        acc = acc | (g[j-1] & pp);
        pp  = pp & p[j-1];
      end
      c[i+1] = acc | (pp & cin);
    end
    gen   = acc;
    prop  = pp;
    sum   = a ^ b ^ c[GROUP-1:0];
    cout  = c[GROUP];
    c_msb = c[GROUP-1];
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor, one GROUP-bit lookahead group per stage.
// Optional CLA_SAT_EN: clamp the sum to the signed extreme on overflow.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = WIDTH / GROUP;

  if (GROUP < 1 || WIDTH == 0 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $fatal(1, "cla_addsub_pipe: WIDTH must be a positive multiple of GROUP");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sel_w [STAGES];
  logic [WIDTH-1:0] sel_b [STAGES];
  logic             sel_c [STAGES];
  logic             sel_v [STAGES];
  logic [WIDTH-1:0] nxt_w [STAGES];
  logic [GROUP-1:0] g_sum [STAGES];
  logic             g_gen [STAGES];
  logic             g_prop[STAGES];
  logic             g_co  [STAGES];
  logic             g_cm  [STAGES];
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] d_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] sum_n;
  alu_flags_t       flags_n;
  alu_flags_t       flags_q;
  logic             unused_taps;

  assign stall    = v_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  // Stage word is skewed: bits below the active group already hold sum,
  // bits from the active group upward still hold operand A.
  always_comb begin
    b_eff = sub ? ~b : b;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        sel_w[k] = a;
        sel_b[k] = b_eff;
        sel_c[k] = sub;
        sel_v[k] = in_valid;
      end else begin
        sel_w[k] = d_q[k-1];
        sel_b[k] = b_q[k-1];
        sel_c[k] = c_q[k-1];
        sel_v[k] = v_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (sel_w[k][k*GROUP +: GROUP]),
      .b    (sel_b[k][k*GROUP +: GROUP]),
      .cin  (sel_c[k]),
      .sum  (g_sum[k]),
      .gen  (g_gen[k]),
      .prop (g_prop[k]),
      .cout (g_co[k]),
      .c_msb(g_cm[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt_w[k] = sel_w[k];
      nxt_w[k][k*GROUP +: GROUP] = g_sum[k];
    end
    sum_n        = nxt_w[STAGES-1];
    flags_n.cout = g_co[STAGES-1];
    flags_n.ovf  = g_cm[STAGES-1] ^ g_co[STAGES-1];
`ifdef CLA_SAT_EN
    // The last stage word still carries A's MSB, which picks the clamp direction.
    if (flags_n.ovf) begin
      sum_n = sel_w[STAGES-1][WIDTH-1] ? ~({WIDTH{1'b1}} >> 1) : ({WIDTH{1'b1}} >> 1);
    end
`endif
    flags_n.zero = ~|sum_n;
  end

  // Group generate/propagate and the pass-through copies in the last stage
  // are not needed by this datapath.
  always_comb begin
    unused_taps = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      unused_taps = unused_taps ^ (^b_q[k]) ^ g_gen[k] ^ g_prop[k] ^ g_cm[k] ^ c_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      flags_q <= '0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= sel_v[k];
        if (sel_v[k]) begin
          d_q[k] <= (k == STAGES-1) ? sum_n : nxt_w[k];
          b_q[k] <= sel_b[k];
          c_q[k] <= g_co[k];
        end
      end
      if (sel_v[STAGES-1]) begin
        flags_q <= flags_n;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = d_q[STAGES-1];
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe at WIDTH=16, GROUP=4 (latency 4).
module tb_cla_addsub_pipe;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  exp_t         sb[$];
  int           n_checks;
  int           n_fails;
  int           n_pops;
  logic         held;
  logic [W-1:0] h_sum;
  logic [2:0]   h_flags;

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    exp_t       r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic [W-1:0] low;
    bb   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms};
    low  = {1'b0, ma[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, ms};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = low[W-1] ^ full[W];
`ifdef CLA_SAT_EN
    if (r.ovf) r.sum = ma[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic pop_compare();
    exp_t e;
    check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_pops++;
      check("sum", {16'd0, sum}, {16'd0, e.sum});
      check("cout", {31'd0, cout}, {31'd0, e.cout});
      check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      check("zero", {31'd0, zero}, {31'd0, e.zero});
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic cycle(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic ts, input logic ordy, output logic acc, output logic seen);
    in_valid  = v;
    a         = ta;
    b         = tbv;
    sub       = ts;
    out_ready = ordy;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !ordy)});
    if (held) begin
      check("hold_sum", {16'd0, sum}, {16'd0, h_sum});
      check("hold_flags", {29'd0, cout, ovf, zero}, {29'd0, h_flags});
    end
    seen = out_valid;
    if (out_valid && ordy) pop_compare();
    held    = out_valid && !ordy;
    h_sum   = sum;
    h_flags = {cout, ovf, zero};
    acc = v && in_ready;
    if (acc) sb.push_back(model(ta, tbv, ts));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts);
    logic acc;
    logic seen;
    int   lat;
    cycle(1'b1, ta, tbv, ts, 1'b1, acc, seen);
    check("accept", {31'd0, acc}, 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      lat++;
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, seen);
    end
    check("latency", lat, 32'd4);
  endtask

  initial begin
    logic         acc;
    logic         seen;
    logic         ordy;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           acc_cnt;
    int           pops0;
    int           cyc;

    n_checks  = 0;
    n_fails   = 0;
    n_pops    = 0;
    held      = 1'b0;
    h_sum     = '0;
    h_flags   = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h0000, 16'h0001, 1'b1);
    send(16'h0005, 16'h0005, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h0001, 1'b1);

    // Random stream with back-pressure; a beat is held until accepted.
    acc_cnt = 0;
    pops0   = n_pops;
    cyc     = 0;
    ra = 16'($urandom);
    rb = 16'($urandom);
    rs = 1'($urandom);
    while ((acc_cnt < 8 || sb.size() != 0) && cyc < 200) begin
      cyc++;
      ordy = 1'($urandom_range(0, 1));
      if (acc_cnt < 8) begin
        cycle(1'b1, ra, rb, rs, ordy, acc, seen);
        if (acc) begin
          acc_cnt++;
          ra = 16'($urandom);
          rb = 16'($urandom);
          rs = 1'($urandom);
        end
      end else begin
        cycle(1'b0, '0, '0, 1'b0, ordy, acc, seen);
      end
    end
    check("stream_accepted", acc_cnt, 32'd8);
    check("stream_popped", n_pops - pops0, 32'd8);
    check("stream_drained", sb.size(), 32'd0);

    // Reset with the pipe full and the head beat stalled.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc, seen);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    check("mid_rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    sb.delete();
    held = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(16'h1234, 16'h0F0F, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, seen);
    check("post_rst_no_stale", {31'd0, seen}, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
